imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter IMEM_W, default 13, meaning instruction-memory byte-address width; depth is 2**(IMEM_W-2) 32-bit words.
REQ-002 SHALL have port clk_i  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_ni  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port start_i  input  1  begin a load session; level sampled per cycle.
REQ-005 SHALL have port rx_valid_i  input  1  incoming byte valid.
REQ-006 SHALL have port rx_data_i  input  8  incoming byte.
REQ-007 SHALL have port rx_ready_o  output  1  loader accepts a byte this cycle; a transfer occurs when rx_valid_i and rx_ready_o are both 1.
REQ-008 SHALL have port we_o  output  1  one-cycle write strobe to instruction memory.
REQ-009 SHALL have port waddr_o  output  IMEM_W  byte address of the write; bits [1:0] are always 0.
REQ-010 SHALL have port wdata_o  output  32  word to write.
REQ-011 SHALL have port busy_o  output  1  session in progress; core is held in reset while 1.
REQ-012 SHALL have port done_o  output  1  session completed successfully; level.
REQ-013 SHALL have port err_o  output  1  session aborted because of a length error; level.

Function
REQ-014 SHALL implement states IDLE, LEN_LO, LEN_HI, DATA, DONE, ERR.
REQ-015 IDLE, DONE and ERR SHALL go to LEN_LO when start_i=1; start_i SHALL be ignored in LEN_LO, LEN_HI and DATA.
REQ-016 rx_ready_o SHALL be 1 exactly in LEN_LO, LEN_HI and DATA; no backpressure occurs inside a session.
REQ-017 In LEN_LO, an accepted byte SHALL become word count N[7:0] and the FSM SHALL go to LEN_HI.
REQ-018 In LEN_HI, an accepted byte SHALL become N[15:8]. The next state SHALL be DONE if N=0, ERR if N>2**(IMEM_W-2), and DATA otherwise.
REQ-019 In DATA, bytes SHALL be assembled little-endian: byte k of a word (k=0..3) goes to wdata bits [8k+7:8k], using a 2-bit byte counter that wraps 3->0.
REQ-020 The cycle after the 4th byte of a word is accepted, we_o SHALL be 1 for exactly one cycle. In that cycle wdata_o SHALL hold the assembled word and waddr_o SHALL equal word_index*4, with word_index starting at 0 and incrementing by 1 per word.
REQ-021 Byte acceptance SHALL continue in the same cycle as a we_o pulse; a back-to-back stream SHALL lose no bytes.
REQ-022 After the 4th byte of word N-1 is accepted, the FSM SHALL go to DONE; the final we_o pulse SHALL occur in the first DONE cycle.
REQ-023 Cycles with rx_valid_i=0 SHALL leave all counters and partial data unchanged.
REQ-024 busy_o SHALL be 1 in LEN_LO, LEN_HI and DATA, and also during the trailing we_o cycle; it is 0 otherwise.
REQ-025 done_o SHALL be 1 only in DONE after the final write; err_o SHALL be 1 only in ERR. Both SHALL clear on the cycle LEN_LO is entered.
REQ-026 In ERR, we_o SHALL never pulse and incoming bytes SHALL NOT be accepted.
REQ-027 Restarting from DONE or ERR SHALL clear word_index, the byte counter and N.
REQ-028 waddr_o and wdata_o SHALL be registered and SHALL hold their last values when we_o=0.

Reset
REQ-029 rst_ni=0 SHALL asynchronously force IDLE, clear word_index, the byte counter, N, wdata_o and waddr_o, and drive we_o, rx_ready_o, busy_o, done_o and err_o to 0.
REQ-030 Reset asserted mid-session SHALL discard any partial word without a write; a new session requires start_i after release.

Verification
REQ-031 Start, stream 02 00 EF BE AD DE 78 56 34 12 back-to-back -> we_o at addr 0x000 with data 0xDEADBEEF, then at addr 0x004 with data 0x12345678; done_o=1, busy_o=0.
REQ-032 Start, stream 00 00 -> no we_o pulse; done_o=1 two cycles after start.
REQ-033 IMEM_W=13: start, stream 01 08 (N=2049) -> err_o=1, rx_ready_o=0, no we_o; a following start_i clears err_o.
REQ-034 N=1 with rx_valid_i toggling every other cycle -> exactly one we_o pulse, with data equal to the 4 bytes in little-endian order.
REQ-035 rst_ni low after 2 data bytes, then a new session with N=1 -> the first write is at addr 0 and contains only the new bytes.
REQ-036 N=2048 with IMEM_W=13 -> the last write is at addr 0x1FFC, followed by done_o=1.

Source files
------------

// File: rtl/imem_loader.sv
// imem_loader: receives a length-prefixed byte stream and writes it into
// instruction memory as little-endian 32-bit words. Intended to run while the
// core is held in reset (busy_o).
//
// Ports:
//   clk_i, rst_ni            clock, async active-low reset
//   start_i                  begin a new load session (IDLE/DONE/ERR only)
//   rx_valid_i, rx_data_i    incoming byte stream
//   rx_ready_o               byte accepted when rx_valid_i & rx_ready_o
//   we_o, waddr_o, wdata_o   one-cycle word write to instruction memory
//   busy_o, done_o, err_o    session status levels
module imem_loader #(
    parameter int unsigned IMEM_W = 13
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic              rx_valid_i,
    input  logic [7:0]        rx_data_i,
    output logic              rx_ready_o,
    output logic              we_o,
    output logic [IMEM_W-1:0] waddr_o,
    output logic [31:0]       wdata_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o
);

    localparam int unsigned WIDX_W = IMEM_W - 2;
    localparam int unsigned DEPTH  = 1 << WIDX_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_DONE,
        S_ERR
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [15:0]         r_len;
    logic [WIDX_W-1:0]   r_word_idx;
    logic [1:0]          r_byte_cnt;
    logic [23:0]         r_asm;
    logic [31:0]         r_wdata;
    logic [IMEM_W-1:0]   r_waddr;
    logic                r_we;
    logic                r_rx_ready;
    logic                r_busy;
    logic                r_done;
    logic                r_err;

    logic                w_accept;
    logic                w_restart;
    logic                w_word_done;
    logic                w_last_word;
    logic                w_sess_nxt;
    logic [15:0]         w_len_full;

    // rx_ready_o is registered from the next state, so it mirrors the current state
    assign w_accept    = rx_valid_i & r_rx_ready;
    assign w_len_full  = {rx_data_i, r_len[7:0]};
    assign w_word_done = (r_state == S_DATA) && w_accept && (r_byte_cnt == 2'd3);
    assign w_last_word = (16'(r_word_idx) == (r_len - 16'd1));
    assign w_restart   = start_i &&
                         ((r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERR));

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE, S_DONE, S_ERR: begin
                if (start_i) w_state_nxt = S_LEN_LO;
            end
            S_LEN_LO: begin
                if (w_accept) w_state_nxt = S_LEN_HI;
            end
            S_LEN_HI: begin
                if (w_accept) begin
                    if (w_len_full == 16'd0)
                        w_state_nxt = S_DONE;
                    else if (32'(w_len_full) > DEPTH)
                        w_state_nxt = S_ERR;
                    else
                        w_state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                if (w_word_done && w_last_word) w_state_nxt = S_DONE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
        w_sess_nxt = (w_state_nxt == S_LEN_LO) || (w_state_nxt == S_LEN_HI) ||
                     (w_state_nxt == S_DATA);
    end

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    // Registered status outputs; done waits until the trailing write has issued
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rx_ready <= 1'b0;
            r_we       <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_rx_ready <= w_sess_nxt;
            r_we       <= w_word_done;
            r_busy     <= w_sess_nxt | w_word_done;
            r_done     <= (w_state_nxt == S_DONE) & ~w_word_done;
            r_err      <= (w_state_nxt == S_ERR);
        end
    end

    // Length capture, byte assembly and write-port registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_len      <= '0;
            r_word_idx <= '0;
            r_byte_cnt <= '0;
            r_asm      <= '0;
            r_wdata    <= '0;
            r_waddr    <= '0;
        end else if (w_restart) begin
            r_len      <= '0;
            r_word_idx <= '0;
            r_byte_cnt <= '0;
            r_asm      <= '0;
        end else if (w_accept) begin
            unique case (r_state)
                S_LEN_LO: r_len[7:0]  <= rx_data_i;
                S_LEN_HI: r_len[15:8] <= rx_data_i;
                S_DATA: begin
                    r_byte_cnt <= 2'(r_byte_cnt + 2'd1);
                    unique case (r_byte_cnt)
                        2'd0: r_asm[7:0]   <= rx_data_i;
                        2'd1: r_asm[15:8]  <= rx_data_i;
                        2'd2: r_asm[23:16] <= rx_data_i;
                        default: begin
                            // partial word is kept separate so wdata_o holds between writes
                            r_wdata    <= {rx_data_i, r_asm};
                            r_waddr    <= {r_word_idx, 2'b00};
                            r_word_idx <= WIDX_W'(r_word_idx + 1'b1);
                        end
                    endcase
                end
                default: ;
            endcase
        end
    end

    assign rx_ready_o = r_rx_ready;
    assign we_o       = r_we;
    assign waddr_o    = r_waddr;
    assign wdata_o    = r_wdata;
    assign busy_o     = r_busy;
    assign done_o     = r_done;
    assign err_o      = r_err;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: scoreboard bench for imem_loader. Expected writes are queued
// as bytes are driven and compared when we_o pulses.
module tb_imem_loader;

    localparam int unsigned IMEM_W = 13;

    typedef struct {
        logic [IMEM_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              rx_ready;
    logic              we;
    logic [IMEM_W-1:0] waddr;
    logic [31:0]       wdata;
    logic              busy;
    logic              done;
    logic              err;

    wr_t exp_q[$];
    int  n_checks = 0;
    int  n_pass   = 0;
    int  n_we     = 0;

    imem_loader #(.IMEM_W(IMEM_W)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .start_i    (start),
        .rx_valid_i (rx_valid),
        .rx_data_i  (rx_data),
        .rx_ready_o (rx_ready),
        .we_o       (we),
        .waddr_o    (waddr),
        .wdata_o    (wdata),
        .busy_o     (busy),
        .done_o     (done),
        .err_o      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    endtask

    // Write monitor: every we_o pulse must match the head of the scoreboard
    always @(negedge clk) begin
        if (rst_n && we) begin
            n_we++;
            if (exp_q.size() == 0) begin
                check("unexpected_we", 32'(waddr), 32'hFFFF_FFFF);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("waddr", 32'(waddr), 32'(e.addr));
                check("wdata", wdata, e.data);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    // All driver tasks start and end on a falling edge
    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic gap();
        @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] w, input logic [IMEM_W-1:0] a, input bit toggle);
        wr_t e;
        e.addr = a;
        e.data = w;
        exp_q.push_back(e);
        for (int k = 0; k < 4; k++) begin
            send(w[8*k +: 8]);
            if (toggle) gap();
        end
    endtask

    task automatic wait_end(input string tag);
        for (int i = 0; i < 20; i++) begin
            if (done || err) break;
            @(negedge clk);
        end
        check({tag, "_end"}, 32'(done | err), 32'd1);
        check({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int we_before;
        rst_n    = 1'b0;
        start    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_outs", {25'd0, we, rx_ready, busy, done, err, 2'b00}, 32'd0);
        check("rst_waddr", 32'(waddr), 32'd0);
        check("rst_wdata", wdata, 32'd0);
        rst_n = 1'b1;
        gap();

        // Two words back-to-back
        do_start();
        check("sess_ready", 32'(rx_ready), 32'd1);
        check("sess_busy", 32'(busy), 32'd1);
        send(8'h02); send(8'h00);
        send_word(32'hDEADBEEF, 13'h000, 1'b0);
        send_word(32'h12345678, 13'h004, 1'b0);
        check("trail_busy", {30'd0, busy, we}, 32'd3);
        check("trail_done", 32'(done), 32'd0);
        wait_end("two_words");
        check("two_words_done", {30'd0, done, busy}, 32'd2);
        check("two_words_cnt", 32'(n_we), 32'd2);

        // Empty image: done two cycles after the start cycle, write port holds
        we_before = n_we;
        do_start();
        check("empty_done_clr", 32'(done), 32'd0);
        send(8'h00); send(8'h00);
        check("empty_done", {30'd0, done, busy}, 32'd2);
        check("empty_hold_addr", 32'(waddr), 32'h004);
        check("empty_hold_data", wdata, 32'h12345678);
        check("empty_no_we", 32'(n_we - we_before), 32'd0);

        // Oversize length 2049 -> error, bytes refused, restart clears it
        we_before = n_we;
        do_start();
        send(8'h01); send(8'h08);
        check("err_flags", {28'd0, err, rx_ready, busy, done}, 32'h8);
        send(8'h55); send(8'h66);
        check("err_no_we", 32'(n_we - we_before), 32'd0);
        do_start();
        check("err_clear", {30'd0, err, rx_ready}, 32'd1);
        send(8'h00); send(8'h00);
        wait_end("after_err");

        // N=1 with idle cycles between bytes
        do_start();
        send(8'h01); gap(); send(8'h00); gap();
        we_before = n_we;
        send_word(32'h44332211, 13'h000, 1'b1);
        wait_end("toggle");
        check("toggle_one_we", 32'(n_we - we_before), 32'd1);

        // Reset mid-word discards the partial word
        do_start();
        send(8'h01); send(8'h00); send(8'hAA); send(8'hBB);
        rst_n = 1'b0;
        #1;
        check("midrst_outs", {27'd0, we, rx_ready, busy, done, err}, 32'd0);
        check("midrst_wdata", wdata, 32'd0);
        gap();
        rst_n = 1'b1;
        gap(); gap();
        check("midrst_idle", {30'd0, rx_ready, busy}, 32'd0);
        do_start();
        send(8'h01); send(8'h00);
        send_word(32'h04030201, 13'h000, 1'b0);
        wait_end("after_rst");

        // Full depth: N=2048, last write at 0x1FFC
        do_start();
        send(8'h00); send(8'h08);
        check("full_not_err", 32'(err), 32'd0);
        for (int i = 0; i < 2048; i++)
            send_word($urandom, 13'(i * 4), 1'b0);
        wait_end("full");
        check("full_last_addr", 32'(waddr), 32'h1FFC);
        check("full_done", {30'd0, done, busy}, 32'd2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
